// File: rtl/pc_redirect_pkg.sv
// rtl/pc_redirect_pkg.sv - shared state encodings and constants for the fetch PC redirect unit
package pc_redirect_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_SETTLE = 2'b01,
    ST_HALTED = 2'b10
  } pc_state_t;

  localparam int          PC_INC           = 2;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and enable
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC holder with branch/jump redirect, flush and settle window
// Optional accepted-redirect counter port taken_count when PC_REDIRECT_COUNT_EN is defined.
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter int                    PC_WIDTH      = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC      = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic [PC_WIDTH-1:0] ex_offset,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic                flush,
  output logic                redirect,
  output logic                halted
`ifdef PC_REDIRECT_COUNT_EN
  ,
  output logic [15:0]         taken_count
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
  localparam logic [PC_WIDTH-1:0] INC         = PC_WIDTH'(PC_INC);

  pc_state_t           state, state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [PC_WIDTH-1:0] br_sum;
  logic [PC_WIDTH-1:0] br_target;
  logic [PC_WIDTH-1:0] jp_target;

  // Targets are halfword aligned; addition wraps modulo 2^PC_WIDTH.
  assign br_sum    = ex_pc + ex_offset;
  assign br_target = {br_sum[PC_WIDTH-1:1], 1'b0};
  assign jp_target = {jump_target[PC_WIDTH-1:1], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cnt;
    case (state)
      ST_RUN: begin
        if (branch) begin
          pc_next    = br_target;
          state_next = ST_SETTLE;
          cnt_next   = SETTLE_LOAD;
        end else if (jump) begin
          pc_next    = jp_target;
          state_next = ST_SETTLE;
          cnt_next   = SETTLE_LOAD;
        end else if (stall) begin
          pc_next = pc;
        end else if (halt) begin
          state_next = ST_HALTED;
        end else begin
          pc_next = pc + INC;
        end
      end
      ST_SETTLE: begin
        // Redirect requests here are wrong-path leftovers and are dropped.
        if (!stall) begin
          pc_next = pc + INC;
          if (cnt == '0) begin
            state_next = ST_RUN;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
      end
      ST_HALTED: begin
        pc_next = pc;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_comb begin
    redirect = (state == ST_RUN) && (branch || jump) && !rst;
    flush    = redirect;
    halted   = (state == ST_HALTED);
  end

`ifdef PC_REDIRECT_COUNT_EN
  sat_counter #(
    .WIDTH(16)
  ) u_taken_count (
    .clk  (clk),
    .clr  (rst),
    .en   (redirect),
    .count(taken_count)
  );
`endif

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter and redirect controller for the fetch stage. It consumes the `branch` decision from the EX-stage branch comparator and the ID-stage jump request. It holds and advances the PC, and loads the branch or jump target on a redirect. It drives the flush that kills wrong-path instructions in IF/ID, then runs a short settle window before normal fetch resumes.

## Interface
- `PC_WIDTH`, 16, PC and address width.
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `SETTLE_CYCLES`, 2, cycles after a redirect during which further redirects are ignored (≥1).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hazard stall; freezes PC.
- `branch` in 1: taken-branch decision from the branch comparator (EX stage).
- `ex_pc` in PC_WIDTH: PC of the instruction in EX.
- `ex_offset` in PC_WIDTH: signed byte offset of that branch.
- `jump` in 1: unconditional jump request (ID stage).
- `jump_target` in PC_WIDTH: absolute jump address.
- `halt` in 1: halt request (ID stage).
- `pc` out PC_WIDTH: current fetch address (registered).
- `flush` out 1: kill IF/ID contents this cycle (combinational).
- `redirect` out 1: a redirect is accepted this cycle (combinational).
- `halted` out 1: high in HALTED state (registered).
- `taken_count` out 16: accepted-redirect counter. Present only with `PC_REDIRECT_COUNT_EN`.

## Operation
- States: RUN, SETTLE, HALTED. Reset → RUN with `pc=RESET_PC`, settle counter 0, `halted=0`, `taken_count=0`.
- Input priority, highest first: `rst` > `branch` > `jump` > `stall` > `halt` > increment.
- RUN:
  - `branch` high → `pc ← (ex_pc + ex_offset) & ~1`; go to SETTLE with counter `SETTLE_CYCLES-1`.
  - Else `jump` high → `pc ← jump_target & ~1`; go to SETTLE.
  - Else `stall` → hold.
  - Else `halt` → hold `pc`, go to HALTED.
  - Else `pc ← pc + 2`.
- A redirect overrides `stall`. When `branch` and `jump` are high together, the branch wins and the jump is dropped as wrong-path.
- `redirect = flush = (state==RUN) & (branch|jump) & ~rst`.
- SETTLE:
  - `branch`, `jump` and `halt` are ignored.
  - `stall` → hold `pc` and the counter.
  - Otherwise `pc ← pc + 2`, counter decrements, and the state goes to RUN when the counter is 0.
- HALTED: `pc` holds and all inputs except `rst` are ignored. `halted=1`. Exit only via `rst`.
- Arithmetic is modulo 2^PC_WIDTH.
  - `pc + 2` from 16'hFFFE wraps to 16'h0000.
  - Target addition wraps silently.
  - Bit 0 of every loaded target is forced to 0.
- `rst` mid-SETTLE or in HALTED → RUN with `pc=RESET_PC` on the next edge. `flush` is 0 while `rst` is high.

## Timing
- Redirect latency 1: `branch` sampled high at edge N, and `pc` shows the target after edge N.
- `flush` is asserted in the same cycle as `branch`/`jump`, so the IF/ID and ID/EX registers latch bubbles at edge N.
- Wrong-path fetches: exactly one per redirect (the instruction at the old `pc`), killed by `flush`.
- Minimum spacing between accepted redirects is `SETTLE_CYCLES+1` cycles, plus any stall cycles.
- `halted` rises one cycle after `halt` is accepted.

## Configuration
- `PC_REDIRECT_COUNT_EN` defined:
  - `taken_count` port exists.
  - It increments by 1 on each cycle with `redirect=1` and saturates at 16'hFFFF.
  - It clears on `rst`.
- Undefined: port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package/header `pc_redirect_pkg`: state encodings (RUN=2'b00, SETTLE=2'b01, HALTED=2'b10), `PC_INC=2`, default `RESET_PC`.
- One sub-module, `sat_counter`: parameterized width, synchronous clear, enable, saturate at all-ones. It is instantiated only under `PC_REDIRECT_COUNT_EN`.

## Test plan
- Reset, then 4 free-run cycles → `pc` = 0000, 0002, 0004, 0006, 0008; `flush=0`; `halted=0`.
- `pc`=0010 with `branch=1`, `ex_pc`=000C, `ex_offset`=FFF8 → `flush=1` that cycle, next `pc`=0004. A `branch=1` held over the next 2 cycles is ignored (`pc`=0006, 0008) and is accepted on the third cycle.
- `branch` and `jump` (`jump_target`=0100) together, with `stall=1` → `pc` loads the branch target; the jump and the stall are ignored; `taken_count` +1.
- `pc`=FFFE, no events → `pc`=0000; `jump_target`=0101 → `pc`=0100.
- `halt=1` at `pc`=0020 → `pc` stays 0020 and `halted=1` from the next cycle. Later `branch=1` → no change. `rst` → `pc`=0000, RUN.
- `rst` asserted in the first SETTLE cycle → next `pc`=RESET_PC, state RUN, `taken_count`=0. With the macro undefined, the build has no `taken_count` port.
